// File: rtl/store_capture_display_pkg.sv
// Shared types for the store capture/display block.
// Entry layout, display FSM states and nibble helper.
package store_capture_pkg;

    typedef struct packed {
        logic [15:0] adr;
        logic [31:0] data;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        LINGER
    } disp_state_t;

    localparam int ENTRY_W = $bits(store_entry_t);

    // 0-3 pick write_data nibbles, 4-7 pick address nibbles
    function automatic logic [3:0] pick_nibble(
        input store_entry_t e,
        input logic [2:0]   sel
    );
        logic [3:0] r;
        r = '0;
        unique case (1'b1)
            sel[2]:  r = e.adr[{sel[1:0], 2'b00} +: 4];
            !sel[2]: r = e.data[{sel[1:0], 2'b00} +: 4];
        endcase
        return r;
    endfunction

    // Unsigned window test done by borrow bits so it stays
    // meaningful for any lo/hi, including the full range.
    function automatic logic in_window(
        input logic [31:0] a,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [32:0] dl;
        logic [32:0] dh;
        dl = {1'b0, a} - {1'b0, lo};
        dh = {1'b0, hi} - {1'b0, a};
        return ~dl[32] & ~dh[32];
    endfunction

endpackage

// File: rtl/store_capture_display_if.sv
// CPU data-memory store bus as seen by the snooper.
// The core drives it; the capture block only listens.
interface store_capture_display_if;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;

    modport master (
        output mem_write,
        output data_adr,
        output write_data
    );

    modport slave (
        input mem_write,
        input data_adr,
        input write_data
    );
endinterface

// File: rtl/store_capture_display_fifo.sv
// Small synchronous FIFO with registered count.
// Push when full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !clr && !empty;
    assign do_push = push && !clr && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap modulo DEPTH; count kept alongside
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/store_capture_display.sv
// Snoops CPU stores in an address window, queues them and
// shows one at a time for a hold period on the 7-seg display.
module store_capture_display
    import store_capture_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          HOLD_CYCLES = 25_000_000,
    parameter logic [31:0] ADDR_LO     = 32'h0,
    parameter logic [31:0] ADDR_HI     = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    store_capture_display_if.slave     bus,
    input  logic                       step,
    input  logic                       clr,
    input  logic [2:0]                 digit_sel,
    output logic [3:0]                 nibble,
    output logic [15:0]                disp_adr,
    output logic [31:0]                disp_data,
    output logic                       disp_valid,
    output logic                       disp_stale,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);
    localparam int HW = $clog2(HOLD_CYCLES);

    disp_state_t  state;
    store_entry_t disp;
    store_entry_t din;
    logic [ENTRY_W-1:0] dout_raw;
    store_entry_t head;
    logic [HW-1:0] hold_cnt;
    logic          qualify;
    logic          expired;
    logic          advance;
    logic          load;
    logic          full;
    logic          empty;

    assign qualify = bus.mem_write
                   && in_window(bus.data_adr, ADDR_LO, ADDR_HI);
    assign din     = '{adr: bus.data_adr[15:0], data: bus.write_data};
    assign head    = store_entry_t'(dout_raw);
    assign expired = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign advance = step || expired;

    // pop only from registered, non-empty count
    always_comb begin
        load = 1'b0;
        if (!clr && !empty) begin
            unique case (state)
                IDLE:    load = 1'b1;
                SHOW:    load = advance;
                LINGER:  load = 1'b1;
                default: load = 1'b0;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (qualify),
        .pop   (load),
        .clr   (clr),
        .din   (din),
        .dout  (dout_raw),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // display FSM, hold counter and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            disp       <= '0;
            hold_cnt   <= '0;
            disp_valid <= 1'b0;
            disp_stale <= 1'b0;
            overflow   <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            disp       <= '0;
            hold_cnt   <= '0;
            disp_valid <= 1'b0;
            disp_stale <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (qualify && full && !load) overflow <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        disp       <= head;
                        hold_cnt   <= '0;
                        disp_valid <= 1'b1;
                        state      <= SHOW;
                    end
                end
                SHOW: begin
                    if (advance) begin
                        if (load) begin
                            disp     <= head;
                            hold_cnt <= '0;
                        end else begin
                            disp_stale <= 1'b1;
                            state      <= LINGER;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LINGER: begin
                    if (load) begin
                        disp       <= head;
                        hold_cnt   <= '0;
                        disp_stale <= 1'b0;
                        state      <= SHOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign disp_adr  = disp.adr;
    assign disp_data = disp.data;
    assign nibble    = pick_nibble(disp, digit_sel);
endmodule

// File: tb/tb_store_capture_display.sv
// Directed bench for store_capture_display.
// Queue-based reference model checked every cycle.
module tb_store_capture_display;
    localparam int          DEPTH = 4;
    localparam int          HOLD  = 4;
    localparam logic [31:0] LO    = 32'h100;
    localparam logic [31:0] HI    = 32'h1FF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  digit_sel = 3'd0;
    logic [3:0]  nibble;
    logic [15:0] disp_adr;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        disp_stale;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    store_capture_display_if bus_if ();

    store_capture_display #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .ADDR_LO     (LO),
        .ADDR_HI     (HI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .step       (step),
        .clr        (clr),
        .digit_sel  (digit_sel),
        .nibble     (nibble),
        .disp_adr   (disp_adr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_stale (disp_stale),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // reference model: queue of pending stores plus shown entry
    logic [47:0] m_q[$];
    logic [15:0] m_adr   = '0;
    logic [31:0] m_data  = '0;
    logic        m_valid = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_ovf   = 1'b0;
    int          m_shown = 0;

    task automatic model_clear();
        m_q.delete();
        m_adr   = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_stale = 1'b0;
        m_ovf   = 1'b0;
        m_shown = 0;
    endtask

    task automatic model_edge();
        bit          qual;
        bit          take;
        int          cnt;
        logic [47:0] h;
        if (clr) begin
            model_clear();
            return;
        end
        qual = bus_if.mem_write
            && bus_if.data_adr >= LO && bus_if.data_adr <= HI;
        cnt  = m_q.size();
        take = 1'b0;
        if (!m_valid || m_stale) begin
            take = (cnt > 0);
        end else if (step || m_shown == HOLD - 1) begin
            if (cnt > 0) take = 1'b1;
            else m_stale = 1'b1;
        end else begin
            m_shown++;
        end
        if (take) begin
            h       = m_q.pop_front();
            m_adr   = h[47:32];
            m_data  = h[31:0];
            m_valid = 1'b1;
            m_stale = 1'b0;
            m_shown = 0;
        end
        if (qual) begin
            if (cnt < DEPTH || take)
                m_q.push_back({bus_if.data_adr[15:0], bus_if.write_data});
            else
                m_ovf = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_clear();
        else model_edge();
    end

    function automatic logic [3:0] exp_nibble(input logic [2:0] s);
        logic [31:0] w;
        int          k;
        w = (s < 3'd4) ? m_data : {16'h0, m_adr};
        k = (s < 3'd4) ? int'(s) : int'(s) - 4;
        return 4'((w >> (4 * k)) & 32'hF);
    endfunction

    // per-cycle comparison against the model
    always @(negedge clk) begin
        n_tests++;
        if (disp_data !== m_data || disp_adr !== m_adr
            || disp_valid !== m_valid || disp_stale !== m_stale
            || overflow !== m_ovf
            || int'(fifo_count) != m_q.size()
            || nibble !== exp_nibble(digit_sel)) begin
            n_fail++;
            $display("FAIL cycle@%0t: got d=%h a=%h v=%b s=%b o=%b c=%0d n=%h; expected d=%h a=%h v=%b s=%b o=%b c=%0d n=%h",
                $time, disp_data, disp_adr, disp_valid, disp_stale,
                overflow, fifo_count, nibble, m_data, m_adr, m_valid,
                m_stale, m_ovf, m_q.size(), exp_nibble(digit_sel));
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // wait for the next sampling edge, return 2ns after it
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.mem_write  = 1'b1;
        bus_if.data_adr   = a;
        bus_if.write_data = d;
        cyc();
        bus_if.mem_write  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.mem_write  = 1'b0;
        bus_if.data_adr   = '0;
        bus_if.write_data = '0;
        #23;
        chk("reset_valid", 32'(disp_valid), 32'h0);
        chk("reset_count", 32'(fifo_count), 32'h0);
        chk("reset_nibble", 32'(nibble), 32'h0);
        rst = 1'b1;
        cyc();

        // single store, 2-cycle latency, nibble select
        store(32'h104, 32'hDEAD_BEEF);
        chk("t1_count_after_N", 32'(fifo_count), 32'h1);
        chk("t1_valid_after_N", 32'(disp_valid), 32'h0);
        cyc();
        chk("t1_data", disp_data, 32'hDEAD_BEEF);
        chk("t1_adr", 32'(disp_adr), 32'h0104);
        chk("t1_valid", 32'(disp_valid), 32'h1);
        digit_sel = 3'd0; #1;
        chk("t1_nib0", 32'(nibble), 32'hF);
        digit_sel = 3'd3; #1;
        chk("t1_nib3", 32'(nibble), 32'hB);
        digit_sel = 3'd4; #1;
        chk("t1_nib4", 32'(nibble), 32'h4);
        repeat (5) cyc();
        chk("t1_stale", 32'(disp_stale), 32'h1);
        chk("t1_kept", disp_data, 32'hDEAD_BEEF);

        // out-of-window stores are ignored
        pulse_clr();
        store(32'h0FC, 32'h1111_1111);
        store(32'h200, 32'h2222_2222);
        cyc();
        chk("t2_count", 32'(fifo_count), 32'h0);
        chk("t2_valid", 32'(disp_valid), 32'h0);

        // 7 back-to-back stores: 1..6 accepted, 7 dropped
        digit_sel = 3'd1;
        for (int i = 1; i <= 7; i++) store(32'h100 + 32'(4 * i), 32'(i));
        chk("t3_ovf", 32'(overflow), 32'h1);
        repeat (20) cyc();
        chk("t3_stale", 32'(disp_stale), 32'h1);
        chk("t3_last", disp_data, 32'h6);
        chk("t3_ovf_sticky", 32'(overflow), 32'h1);

        // step one cycle after first load
        pulse_clr();
        store(32'h180, 32'hA1);
        store(32'h184, 32'hA2);
        chk("t4_first", disp_data, 32'hA1);
        pulse_step();
        chk("t4_second", disp_data, 32'hA2);
        chk("t4_count", 32'(fifo_count), 32'h0);
        repeat (5) cyc();
        chk("t4_linger", 32'(disp_stale), 32'h1);
        pulse_step();
        chk("t4_step_ignored", 32'(disp_stale), 32'h1);
        chk("t4_data_kept", disp_data, 32'hA2);

        // push at full while display advances
        pulse_clr();
        digit_sel = 3'd6;
        for (int i = 1; i <= 6; i++) store(32'h1F0, 32'h50 + 32'(i));
        chk("t5_count", 32'(fifo_count), 32'h4);
        chk("t5_no_ovf", 32'(overflow), 32'h0);
        chk("t5_disp", disp_data, 32'h52);
        store(32'h1F4, 32'h57);
        chk("t5_drop_ovf", 32'(overflow), 32'h1);
        chk("t5_drop_count", 32'(fifo_count), 32'h4);

        // clr mid-SHOW
        pulse_clr();
        chk("t6_count", 32'(fifo_count), 32'h0);
        chk("t6_ovf", 32'(overflow), 32'h0);
        chk("t6_valid", 32'(disp_valid), 32'h0);
        chk("t6_data", disp_data, 32'h0);

        // async reset mid-SHOW
        store(32'h1F0, 32'h55);
        store(32'h1F4, 32'h66);
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("t7_data", disp_data, 32'h0);
        chk("t7_valid", 32'(disp_valid), 32'h0);
        chk("t7_count", 32'(fifo_count), 32'h0);
        cyc();
        rst = 1'b1;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
